// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// rr_pick scans up to 16 requesters starting at a rotating pointer.
package adder_arb_pkg;

  typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

  localparam int OP_CNT_W = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // Lowest offset from ptr (modulo n) wins; scanning high-to-low lets the
  // smallest offset overwrite any earlier hit.
  function automatic rr_pick_t rr_pick(input logic [15:0] valid,
                                       input logic [3:0]  ptr,
                                       input logic [4:0]  n);
    rr_pick_t   r;
    logic [4:0] j;
    r.found = 1'b0;
    r.idx   = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (5'(k) < n) begin
        j = {1'b0, ptr} + 5'(k);
        if (j >= n) j = j - n;
        if (valid[j[3:0]]) begin
          r.found = 1'b1;
          r.idx   = j[3:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/response bundle between requesters, the response consumer and the arbiter.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
interface adder_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
);
  import adder_arb_pkg::*;

  logic [N_REQ-1:0]            i_req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] i_req_a;
  logic [N_REQ-1:0][WIDTH-1:0] i_req_b;
  logic [N_REQ-1:0]            o_req_ready;
  logic                        o_rsp_valid;
  logic                        i_rsp_ready;
  logic [WIDTH-1:0]            o_rsp_sum;
  logic                        o_rsp_carry;
  logic [ID_W-1:0]             o_rsp_id;
  logic                        o_busy;
  logic [OP_CNT_W-1:0]         o_op_count;
  arb_state_t                  o_dbg_state;
  logic [ID_W-1:0]             o_dbg_rr_ptr;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id,
    output o_busy, o_op_count, o_dbg_state, o_dbg_rr_ptr
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_sum, o_rsp_carry, o_rsp_id,
    input  o_busy, o_op_count, o_dbg_state, o_dbg_rr_ptr
  );

endinterface

// File: rtl/adder_core.sv
// The single shared adder: combinational WIDTH-bit add with carry out.
module adder_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter scheduling N_REQ requesters onto one adder_core instance.
// IDLE grants and captures operands, CALC adds and registers, RESP holds until taken.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  adder_arbiter_if.slave  bus
);

  arb_state_t          state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [WIDTH-1:0]    sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [OP_CNT_W-1:0] op_count_q, op_count_d;

  logic [WIDTH-1:0]    core_sum;
  logic                core_carry;
  logic [15:0]         valid16;
  logic [3:0]          ptr4;
  rr_pick_t            pick;
  logic [ID_W-1:0]     grant_idx;
  logic [N_REQ-1:0]    req_ready;

  adder_core #(.WIDTH(WIDTH)) u_adder_core (
    .i_a     (a_q),
    .i_b     (b_q),
    .o_sum   (core_sum),
    .o_carry (core_carry)
  );

  always_comb begin
    valid16                = '0;
    valid16[N_REQ-1:0]     = bus.i_req_valid;
    ptr4                   = '0;
    ptr4[ID_W-1:0]         = rr_ptr_q;
    pick                   = rr_pick(valid16, ptr4, 5'(N_REQ));
    grant_idx              = ID_W'(pick.idx);

    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        // Ready is gated by reset so no accept is signalled on a reset edge.
        if (pick.found && i_rst_n) begin
          req_ready[grant_idx] = 1'b1;
          a_d      = bus.i_req_a[grant_idx];
          b_d      = bus.i_req_b[grant_idx];
          id_d     = grant_idx;
          rr_ptr_d = (pick.idx == 4'(N_REQ - 1)) ? '0 : ID_W'(pick.idx + 4'd1);
          state_d  = CALC;
        end
      end
      CALC: begin
        sum_d       = core_sum;
        carry_d     = core_carry;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_rsp_valid  = rsp_valid_q;
  assign bus.o_rsp_sum    = sum_q;
  assign bus.o_rsp_carry  = carry_q;
  assign bus.o_rsp_id     = rsp_id_q;
  assign bus.o_busy       = (state_q != IDLE);
  assign bus.o_op_count   = op_count_q;
  assign bus.o_dbg_state  = state_q;
  assign bus.o_dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with 4 requesters and 32-bit operands.
module tb_adder_arbiter;
  import adder_arb_pkg::*;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  adder_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with i_rsp_ready high, starting in an IDLE cycle.
  task automatic run_op(input string tag, input logic [3:0] exp_ready,
                        input logic [31:0] exp_sum, input logic exp_carry,
                        input logic [1:0] exp_id, input logic [15:0] exp_count);
    #1;
    chk({tag, "_ready"}, 64'(bus.o_req_ready), 64'(exp_ready));
    cyc();
    chk({tag, "_ready_low"}, 64'(bus.o_req_ready), 64'(0));
    cyc();
    chk({tag, "_valid"}, 64'(bus.o_rsp_valid), 64'(1));
    chk({tag, "_sum"},   64'(bus.o_rsp_sum),   64'(exp_sum));
    chk({tag, "_carry"}, 64'(bus.o_rsp_carry), 64'(exp_carry));
    chk({tag, "_id"},    64'(bus.o_rsp_id),    64'(exp_id));
    cyc();
    chk({tag, "_count"}, 64'(bus.o_op_count),  64'(exp_count));
    chk({tag, "_drop"},  64'(bus.o_rsp_valid), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 64'(bus.o_req_ready),  64'(0));
    chk({tag, "_valid"}, 64'(bus.o_rsp_valid),  64'(0));
    chk({tag, "_sum"},   64'(bus.o_rsp_sum),    64'(0));
    chk({tag, "_carry"}, 64'(bus.o_rsp_carry),  64'(0));
    chk({tag, "_id"},    64'(bus.o_rsp_id),     64'(0));
    chk({tag, "_busy"},  64'(bus.o_busy),       64'(0));
    chk({tag, "_count"}, 64'(bus.o_op_count),   64'(0));
    chk({tag, "_state"}, 64'(bus.o_dbg_state),  64'(IDLE));
    chk({tag, "_rrptr"}, 64'(bus.o_dbg_rr_ptr), 64'(0));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_a     = '0;
    bus.i_req_b     = '0;
    bus.i_rsp_ready = 1'b0;

    // Reset state; requester 2 already waiting so reset-time ready gating is seen.
    cyc();
    bus.i_req_valid = 4'b0100;
    bus.i_req_a[2]  = 32'd5;
    bus.i_req_b[2]  = 32'd7;
    cyc();
    cyc();
    check_zero("reset");

    // Single request leaving reset.
    rst_n = 1'b1;
    #1;
    chk("single_ready", 64'(bus.o_req_ready), 64'(4'b0100));
    chk("single_busy0", 64'(bus.o_busy), 64'(0));
    cyc();
    bus.i_req_valid = '0;
    #1;
    chk("single_ready_low", 64'(bus.o_req_ready), 64'(0));
    chk("single_busy1", 64'(bus.o_busy), 64'(1));
    chk("single_state", 64'(bus.o_dbg_state), 64'(CALC));
    chk("single_valid_early", 64'(bus.o_rsp_valid), 64'(0));
    cyc();
    chk("single_valid", 64'(bus.o_rsp_valid), 64'(1));
    chk("single_sum",   64'(bus.o_rsp_sum),   64'(12));
    chk("single_carry", 64'(bus.o_rsp_carry), 64'(0));
    chk("single_id",    64'(bus.o_rsp_id),    64'(2));
    chk("single_rrptr", 64'(bus.o_dbg_rr_ptr), 64'(3));
    chk("single_count0", 64'(bus.o_op_count), 64'(0));
    bus.i_rsp_ready = 1'b1;
    cyc();
    chk("single_count", 64'(bus.o_op_count), 64'(1));
    chk("single_drop",  64'(bus.o_rsp_valid), 64'(0));
    chk("single_idle",  64'(bus.o_dbg_state), 64'(IDLE));

    // Round robin from a fresh pointer: sums 1+10, 101+11, 201+12, 301+13.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.i_req_a     = {32'd301, 32'd201, 32'd101, 32'd1};
    bus.i_req_b     = {32'd13,  32'd12,  32'd11,  32'd10};
    bus.i_req_valid = 4'b1111;
    run_op("rr0", 4'b0001, 32'd11,  1'b0, 2'd0, 16'd1);
    run_op("rr1", 4'b0010, 32'd112, 1'b0, 2'd1, 16'd2);
    run_op("rr2", 4'b0100, 32'd213, 1'b0, 2'd2, 16'd3);
    run_op("rr3", 4'b1000, 32'd314, 1'b0, 2'd3, 16'd4);
    run_op("rr4", 4'b0001, 32'd11,  1'b0, 2'd0, 16'd5);

    // Overflow on requester 1, then backpressure with everyone valid.
    bus.i_req_valid = 4'b0010;
    bus.i_req_a[1]  = 32'hFFFF_FFFF;
    bus.i_req_b[1]  = 32'h0000_0002;
    bus.i_rsp_ready = 1'b0;
    #1;
    chk("ovf_ready", 64'(bus.o_req_ready), 64'(4'b0010));
    cyc();
    bus.i_req_valid = 4'b1111;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(bus.o_rsp_valid), 64'(1));
      chk("bp_sum",   64'(bus.o_rsp_sum),   64'(32'h0000_0001));
      chk("bp_carry", 64'(bus.o_rsp_carry), 64'(1));
      chk("bp_id",    64'(bus.o_rsp_id),    64'(1));
      chk("bp_ready", 64'(bus.o_req_ready), 64'(0));
      cyc();
    end
    bus.i_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", 64'(bus.o_req_ready), 64'(0));
    cyc();
    chk("bp_count", 64'(bus.o_op_count), 64'(6));
    chk("bp_next_grant", 64'(bus.o_req_ready), 64'(4'b0100));

    // Reset while requester 2's op is in CALC.
    cyc();
    chk("mid_state", 64'(bus.o_dbg_state), 64'(CALC));
    rst_n = 1'b0;
    cyc();
    check_zero("mid_reset");
    rst_n = 1'b1;
    #1;
    chk("mid_first_grant", 64'(bus.o_req_ready), 64'(4'b0001));
    cyc();
    bus.i_req_valid = 4'b0000;
    #1;
    chk("mid_no_stale_rsp", 64'(bus.o_rsp_valid), 64'(0));
    cyc();
    chk("mid_sum", 64'(bus.o_rsp_sum), 64'(11));
    chk("mid_id",  64'(bus.o_rsp_id),  64'(0));
    cyc();
    chk("mid_count", 64'(bus.o_op_count), 64'(1));

    // Counter saturation from a preloaded 16'hFFFE.
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    #1;
    chk("sat_preload", 64'(bus.o_op_count), 64'(16'hFFFE));
    cyc();
    chk("sat_hold_idle", 64'(bus.o_op_count), 64'(16'hFFFE));
    bus.i_req_a[3]  = 32'd3;
    bus.i_req_b[3]  = 32'd4;
    bus.i_req_valid = 4'b1000;
    run_op("sat0", 4'b1000, 32'd7, 1'b0, 2'd3, 16'hFFFF);
    run_op("sat1", 4'b1000, 32'd7, 1'b0, 2'd3, 16'hFFFF);
    run_op("sat2", 4'b1000, 32'd7, 1'b0, 2'd3, 16'hFFFF);
    bus.i_req_valid = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one adder resource between N_REQ requesters with round-robin arbitration.
- Each requester offers operand pairs on a valid/ready channel. The arbiter grants one requester, captures its operands and performs the add. It returns the sum on a single tagged response channel.
- Sits between requester modules and the adder datapath. Requesters hold no adder of their own.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, operand and sum width in bits.
- ID_W, $clog2(N_REQ), width of the requester ID tag.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst_n  input  1  reset: synchronous, active-low.
- i_req_valid  input  N_REQ  per-requester request valid.
- i_req_a  input  N_REQ x WIDTH  operand A per requester.
- i_req_b  input  N_REQ x WIDTH  operand B per requester.
- o_req_ready  output  N_REQ  one-hot accept strobe; at most one bit set.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumer ready.
- o_rsp_sum  output  WIDTH  (a+b) mod 2^WIDTH.
- o_rsp_carry  output  1  carry out of bit WIDTH-1.
- o_rsp_id  output  ID_W  index of the requester that owns this response.
- o_busy  output  1  high in CALC and RESP states.
- o_op_count  output  16  count of completed responses; saturates at 16'hFFFF.

Behaviour:
- Reset (i_rst_n=0 at a clock edge) forces all of the following:
  - state=IDLE, rr_ptr=0.
  - o_req_ready=0, o_rsp_valid=0, o_rsp_sum=0, o_rsp_carry=0, o_rsp_id=0, o_busy=0, o_op_count=0.
  - Captured operands are cleared.
- Reset mid-operation discards the in-flight operation. No response is emitted for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant goes to the lowest index g at or after rr_ptr, wrapping modulo N_REQ, with i_req_valid[g]=1.
  - o_req_ready[g]=1 combinationally in the same cycle. No grant means o_req_ready=0 and the FSM stays in IDLE.
  - On a grant, the clock edge captures a_q=i_req_a[g], b_q=i_req_b[g], id_q=g, and sets rr_ptr=(g+1) mod N_REQ. Next state is CALC.
- CALC (1 cycle):
  - The shared adder computes {carry,sum}=a_q+b_q at WIDTH+1 bits.
  - Result is registered into o_rsp_sum/o_rsp_carry, and id_q into o_rsp_id. Next state is RESP.
- RESP:
  - o_rsp_valid=1. Sum, carry and id are held stable until i_rsp_ready=1.
  - On the handshake edge: o_rsp_valid drops next cycle, o_op_count increments unless already at 16'hFFFF, and next state is IDLE.
  - No new grant is issued in the handshake cycle; o_req_ready=0 outside IDLE.
- Latency and throughput:
  - Accept at edge t gives o_rsp_valid high from cycle t+2.
  - Minimum issue interval is 3 cycles with i_rsp_ready tied high.
- Requester rules:
  - A requester must hold valid and operands stable until its o_req_ready pulses.
  - Deasserting valid before the grant is legal; that requester is simply skipped.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,N_REQ-1,0. No requester waits more than N_REQ grants.
- Wrap-around:
  - Sums exceeding 2^WIDTH-1 wrap, and o_rsp_carry=1.
  - rr_ptr wraps from N_REQ-1 to 0.
- o_busy = (state != IDLE).

Decomposition:
- Package adder_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;
  - localparam OP_CNT_W=16;
  - the function rr_pick(valid, ptr), returning the grant index and a found flag.
- Sub-module adder_core (WIDTH): combinational, inputs i_a and i_b, outputs o_sum and o_carry. It is instanced once as u_adder_core and is the shared resource being scheduled.
- The arbiter module contains the FSM, rr pointer, operand/result registers and counter.

Test Plan:
- Single request: requester 2 sends a=5, b=7 at reset exit.
  - o_req_ready=4'b0100 for one cycle.
  - Two cycles later: o_rsp_valid=1, sum=12, carry=0, id=2. o_op_count=1 after the handshake.
- Round-robin: all 4 valid continuously, i_rsp_ready=1.
  - Grant order is 0,1,2,3,0, with each grant 3 cycles apart.
  - The id sequence matches; each sum equals its own operands.
- Overflow: a=32'hFFFF_FFFF, b=32'h0000_0002 -> sum=32'h0000_0001, carry=1.
- Backpressure: i_rsp_ready=0 for 5 cycles during RESP.
  - o_rsp_valid, sum and id are held stable.
  - o_req_ready stays 0 for all requesters despite valid requests.
  - The next grant comes one cycle after the handshake.
- Reset mid-operation: assert i_rsp_n... more precisely, i_rst_n=0 during CALC.
  - All outputs are 0 next cycle, no response appears, rr_ptr=0.
  - After release, requester 0 is served first.
- Counter saturation: force o_op_count to 16'hFFFE via a long run or force, then complete 3 ops -> count stays at 16'hFFFF.
